id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

ID/EX pipeline register for the five-stage MIPS core. It sits directly downstream of the instruction decoder and register file, and captures the decoder control word plus the ID-stage operands for the EX stage. It also contains the load-use hazard detector, which drives the PC/IF-ID stall. It inserts bubbles on load-use hazards and on branch flushes, and keeps saturating bubble/flush event counters for performance debug.

## Interface
- CNT_W, 16, width of the bubble and flush event counters
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-low; sampled on clk_i rising edge
- flush_i  in  1  branch resolved taken in MEM; squash the instruction entering EX
- valid_i  in  1  ID stage holds a real instruction
- RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  decoder control bits
- ALU_op_i  in  2  decoder ALU op (00 add, 01 sub/branch, 10 R-format, 11 slti)
- BranchType_i  in  2  00 beq, 01 bgt, 10 bge, 11 bne
- pc_plus4_i, rs_data_i, rt_data_i, imm_i  in  32 each  PC+4, register operands, sign-extended immediate
- rs_addr_i, rt_addr_i, rd_addr_i  in  5 each  register specifiers
- funct_i  in  6  instruction funct field
- all of the above with _o suffix  out  same widths  registered EX-stage copies
- valid_o  out  1  EX stage holds a real instruction
- stall_o  out  1  combinational; hold PC and IF/ID, and bubble this stage
- bubble_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Hazard (combinational): hazard = valid_o & MemRead_o & (rt_addr_o != 0) & valid_i & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)). The comparison is conservative: rt is compared for every opcode.
- stall_o = hazard & ~flush_i & rst_i. Flush overrides stall, and stall is never asserted while in reset.
- Per-edge update, in priority order:
  - rst_i=0: all _o registers, valid_o and both counters go to 0.
  - flush_i=1: all _o registers and valid_o go to 0. flush_cnt_o increments, saturating at all-ones. bubble_cnt_o holds.
  - hazard=1: all _o registers and valid_o go to 0 (bubble). bubble_cnt_o increments, saturating.
  - Otherwise: every _o register loads its _i counterpart and valid_o <= valid_i.
  - When valid_i=0 on a normal load, all control _o bits (RegWrite, MemRead, MemWrite, Branch, MemtoReg) are forced to 0. Data fields still load.
- A bubble is architecturally a nop: RegWrite_o=0, MemRead_o=0, MemWrite_o=0, Branch_o=0, all data fields 0.
- Counters never wrap. At 2^CNT_W-1 they hold.
- The block does no arithmetic on the datapath fields; they are pure pass-through registers.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- Reset: all outputs are 0 after the first rising edge with rst_i=0, including stall_o, which is gated by rst_i.
- stall_o is valid in the same cycle the dependent instruction is in ID. The upstream holds PC and IF/ID for exactly that cycle.
- On the next edge:
  - the load advances out of EX and valid_o=0 (bubble);
  - hazard deasserts because MemRead_o=0;
  - the held instruction is loaded the following edge.
- Net cost of a load-use hazard: exactly one bubble cycle.
- Back-to-back loads:
  - lw $8 followed by lw $9,0($8) stalls once.
  - The second lw then enters EX and can itself stall its consumer.
- Flush in the same cycle as hazard: flush wins, stall_o=0, and only flush_cnt_o increments.
- Reset asserted mid-stall: reset wins, and all state, including counters, clears on that edge.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with random inputs -> all outputs 0, stall_o=0, counters 0.
- Pass-through: valid_i=1, add $3,$1,$2 controls (RegWrite=1, ALU_op=10, RegDst=1), rs_data=5, rt_data=7 -> one edge later the _o fields match exactly, valid_o=1, stall_o=0.
- Load-use:
  - Stimulus: lw $8,4($0) in EX (MemRead_o=1, rt_addr_o=8), then add $9,$8,$1 in ID.
  - Response: stall_o=1 that cycle; next edge valid_o=0 with all controls 0; bubble_cnt_o=1; after the ID input is re-presented, the add enters EX on the following edge.
- Zero register: lw $0 in EX with rs_addr_i=0 in ID -> stall_o=0, no bubble, bubble_cnt_o stays 0.
- Flush vs. stall: same load-use setup plus flush_i=1 -> stall_o=0; next edge all outputs 0; flush_cnt_o=1, bubble_cnt_o=0.
- Saturation: with CNT_W=4, force 20 consecutive flushes -> flush_cnt_o reaches 15 and holds at 15; then rst_i=0 for one edge -> 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-stage fields in, EX-stage copies out,
// plus flush request, load-use stall and event counters.
interface id_ex_pipe_reg_if #(
  parameter int CNT_W = 16
);
  logic              flush_i;
  logic              valid_i;
  logic              RegWrite_i;
  logic              ALUSrc_i;
  logic              RegDst_i;
  logic              Branch_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic              MemtoReg_i;
  logic [1:0]        ALU_op_i;
  logic [1:0]        BranchType_i;
  logic [31:0]       pc_plus4_i;
  logic [31:0]       rs_data_i;
  logic [31:0]       rt_data_i;
  logic [31:0]       imm_i;
  logic [4:0]        rs_addr_i;
  logic [4:0]        rt_addr_i;
  logic [4:0]        rd_addr_i;
  logic [5:0]        funct_i;

  logic              valid_o;
  logic              RegWrite_o;
  logic              ALUSrc_o;
  logic              RegDst_o;
  logic              Branch_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic              MemtoReg_o;
  logic [1:0]        ALU_op_o;
  logic [1:0]        BranchType_o;
  logic [31:0]       pc_plus4_o;
  logic [31:0]       rs_data_o;
  logic [31:0]       rt_data_o;
  logic [31:0]       imm_o;
  logic [4:0]        rs_addr_o;
  logic [4:0]        rt_addr_o;
  logic [4:0]        rd_addr_o;
  logic [5:0]        funct_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport slave (
    input  flush_i, valid_i,
    input  RegWrite_i, ALUSrc_i, RegDst_i, Branch_i,
    input  MemRead_i, MemWrite_i, MemtoReg_i,
    input  ALU_op_i, BranchType_i,
    input  pc_plus4_i, rs_data_i, rt_data_i, imm_i,
    input  rs_addr_i, rt_addr_i, rd_addr_i, funct_i,
    output valid_o,
    output RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
    output MemRead_o, MemWrite_o, MemtoReg_o,
    output ALU_op_o, BranchType_o,
    output pc_plus4_o, rs_data_o, rt_data_o, imm_o,
    output rs_addr_o, rt_addr_o, rd_addr_o, funct_o,
    output stall_o, bubble_cnt_o, flush_cnt_o
  );

  modport master (
    output flush_i, valid_i,
    output RegWrite_i, ALUSrc_i, RegDst_i, Branch_i,
    output MemRead_i, MemWrite_i, MemtoReg_i,
    output ALU_op_i, BranchType_i,
    output pc_plus4_i, rs_data_i, rt_data_i, imm_i,
    output rs_addr_i, rt_addr_i, rd_addr_i, funct_i,
    input  valid_o,
    input  RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
    input  MemRead_o, MemWrite_o, MemtoReg_o,
    input  ALU_op_o, BranchType_o,
    input  pc_plus4_o, rs_data_o, rt_data_o, imm_o,
    input  rs_addr_o, rt_addr_o, rd_addr_o, funct_o,
    input  stall_o, bubble_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble/flush insertion and saturating event counters.
module id_ex_pipe_reg #(
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [1:0]  branch_type;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [5:0]  funct;
  } ex_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  ex_t              id_w;
  ex_t              ex_d;
  ex_t              ex_q;
  logic [CNT_W-1:0] bcnt_d;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] fcnt_d;
  logic [CNT_W-1:0] fcnt_q;
  logic             rt_hit;
  logic             hazard;

  assign id_w.valid       = bus.valid_i;
  assign id_w.reg_write   = bus.RegWrite_i;
  assign id_w.alu_src     = bus.ALUSrc_i;
  assign id_w.reg_dst     = bus.RegDst_i;
  assign id_w.branch      = bus.Branch_i;
  assign id_w.mem_read    = bus.MemRead_i;
  assign id_w.mem_write   = bus.MemWrite_i;
  assign id_w.mem_to_reg  = bus.MemtoReg_i;
  assign id_w.alu_op      = bus.ALU_op_i;
  assign id_w.branch_type = bus.BranchType_i;
  assign id_w.pc_plus4    = bus.pc_plus4_i;
  assign id_w.rs_data     = bus.rs_data_i;
  assign id_w.rt_data     = bus.rt_data_i;
  assign id_w.imm         = bus.imm_i;
  assign id_w.rs_addr     = bus.rs_addr_i;
  assign id_w.rt_addr     = bus.rt_addr_i;
  assign id_w.rd_addr     = bus.rd_addr_i;
  assign id_w.funct       = bus.funct_i;

  // rt of the load is matched against both ID sources for every opcode
  assign rt_hit = (ex_q.rt_addr == bus.rs_addr_i)
                | (ex_q.rt_addr == bus.rt_addr_i);
  assign hazard = ex_q.valid & ex_q.mem_read
                & (ex_q.rt_addr != 5'd0)
                & bus.valid_i & rt_hit;

  assign bus.stall_o = hazard & ~bus.flush_i & rst_i;

  always_comb begin
    ex_d   = id_w;
    bcnt_d = bcnt_q;
    fcnt_d = fcnt_q;
    if (!bus.valid_i) begin
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.branch     = 1'b0;
      ex_d.mem_to_reg = 1'b0;
    end
    if (bus.flush_i) begin
      ex_d = '0;
      if (fcnt_q != CMAX) fcnt_d = fcnt_q + CONE;
    end else if (hazard) begin
      ex_d = '0;
      if (bcnt_q != CMAX) bcnt_d = bcnt_q + CONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q   <= '0;
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ex_q   <= ex_d;
      bcnt_q <= bcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign bus.valid_o      = ex_q.valid;
  assign bus.RegWrite_o   = ex_q.reg_write;
  assign bus.ALUSrc_o     = ex_q.alu_src;
  assign bus.RegDst_o     = ex_q.reg_dst;
  assign bus.Branch_o     = ex_q.branch;
  assign bus.MemRead_o    = ex_q.mem_read;
  assign bus.MemWrite_o   = ex_q.mem_write;
  assign bus.MemtoReg_o   = ex_q.mem_to_reg;
  assign bus.ALU_op_o     = ex_q.alu_op;
  assign bus.BranchType_o = ex_q.branch_type;
  assign bus.pc_plus4_o   = ex_q.pc_plus4;
  assign bus.rs_data_o    = ex_q.rs_data;
  assign bus.rt_data_o    = ex_q.rt_data;
  assign bus.imm_o        = ex_q.imm;
  assign bus.rs_addr_o    = ex_q.rs_addr;
  assign bus.rt_addr_o    = ex_q.rt_addr;
  assign bus.rd_addr_o    = ex_q.rd_addr;
  assign bus.funct_o      = ex_q.funct;
  assign bus.bubble_cnt_o = bcnt_q;
  assign bus.flush_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + randomized bench for id_ex_pipe_reg against a
// cycle-level reference of the ID/EX register rules.
module tb_id_ex_pipe_reg;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [1:0]  branch_type;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [5:0]  funct;
  } f_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  f_t   cur;
  f_t   m;
  int   bcnt;
  int   fcnt;
  int   vectors;
  int   miscompares;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.CNT_W(CW)) bus ();

  id_ex_pipe_reg #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(string tag, logic [191:0] obs,
                     logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.flush_i      = flush;
    bus.valid_i      = cur.valid;
    bus.RegWrite_i   = cur.reg_write;
    bus.ALUSrc_i     = cur.alu_src;
    bus.RegDst_i     = cur.reg_dst;
    bus.Branch_i     = cur.branch;
    bus.MemRead_i    = cur.mem_read;
    bus.MemWrite_i   = cur.mem_write;
    bus.MemtoReg_i   = cur.mem_to_reg;
    bus.ALU_op_i     = cur.alu_op;
    bus.BranchType_i = cur.branch_type;
    bus.pc_plus4_i   = cur.pc_plus4;
    bus.rs_data_i    = cur.rs_data;
    bus.rt_data_i    = cur.rt_data;
    bus.imm_i        = cur.imm;
    bus.rs_addr_i    = cur.rs_addr;
    bus.rt_addr_i    = cur.rt_addr;
    bus.rd_addr_i    = cur.rd_addr;
    bus.funct_i      = cur.funct;
  endtask

  function automatic f_t obs_ex();
    f_t o;
    o.valid       = bus.valid_o;
    o.reg_write   = bus.RegWrite_o;
    o.alu_src     = bus.ALUSrc_o;
    o.reg_dst     = bus.RegDst_o;
    o.branch      = bus.Branch_o;
    o.mem_read    = bus.MemRead_o;
    o.mem_write   = bus.MemWrite_o;
    o.mem_to_reg  = bus.MemtoReg_o;
    o.alu_op      = bus.ALU_op_o;
    o.branch_type = bus.BranchType_o;
    o.pc_plus4    = bus.pc_plus4_o;
    o.rs_data     = bus.rs_data_o;
    o.rt_data     = bus.rt_data_o;
    o.imm         = bus.imm_o;
    o.rs_addr     = bus.rs_addr_o;
    o.rt_addr     = bus.rt_addr_o;
    o.rd_addr     = bus.rd_addr_o;
    o.funct       = bus.funct_o;
    return o;
  endfunction

  // load in EX whose destination is read by the real instruction in ID
  function automatic bit load_use();
    bit dep;
    dep = (m.rt_addr == cur.rs_addr) || (m.rt_addr == cur.rt_addr);
    return m.valid && m.mem_read && (m.rt_addr != 0)
        && cur.valid && dep;
  endfunction

  task automatic cycle(string tag);
    bit h;
    apply();
    h = load_use();
    #3;
    chk({tag, "/stall"}, 192'(bus.stall_o),
        192'(h && !flush && rst));
    @(posedge clk);
    if (!rst) begin
      m = '0; bcnt = 0; fcnt = 0;
    end else if (flush) begin
      m = '0;
      fcnt = (fcnt < CMAX) ? fcnt + 1 : CMAX;
    end else if (h) begin
      m = '0;
      bcnt = (bcnt < CMAX) ? bcnt + 1 : CMAX;
    end else begin
      m = cur;
      if (!cur.valid) begin
        m.reg_write = 0; m.mem_read = 0; m.mem_write = 0;
        m.branch = 0; m.mem_to_reg = 0;
      end
    end
    #1;
    chk({tag, "/ex"}, 192'(obs_ex()), 192'(m));
    chk({tag, "/bcnt"}, 192'(bus.bubble_cnt_o), 192'(bcnt));
    chk({tag, "/fcnt"}, 192'(bus.flush_cnt_o), 192'(fcnt));
  endtask

  task automatic rand_in();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cur = r[$bits(f_t)-1:0];
    cur.valid = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 2) == 0) cur.rs_addr = m.rt_addr;
    if ($urandom_range(0, 2) == 0) cur.rt_addr = m.rt_addr;
    if ($urandom_range(0, 3) == 0) cur.rt_addr = 5'd0;
  endtask

  task automatic lw_in(logic [4:0] rt, logic [4:0] rs);
    cur = '0;
    cur.valid = 1; cur.mem_read = 1; cur.reg_write = 1;
    cur.alu_src = 1; cur.mem_to_reg = 1;
    cur.rt_addr = rt; cur.rs_addr = rs; cur.imm = 32'd4;
    cur.pc_plus4 = 32'h100;
  endtask

  task automatic add_in(logic [4:0] rd, logic [4:0] rs,
                        logic [4:0] rt);
    cur = '0;
    cur.valid = 1; cur.reg_write = 1; cur.reg_dst = 1;
    cur.alu_op = 2'b10; cur.funct = 6'h20;
    cur.rd_addr = rd; cur.rs_addr = rs; cur.rt_addr = rt;
    cur.rs_data = 32'd5; cur.rt_data = 32'd7;
    cur.pc_plus4 = 32'h104;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m = '0; bcnt = 0; fcnt = 0;
    rst = 0; flush = 0; cur = '0;

    // reset with random inputs
    repeat (2) begin
      rand_in(); flush = 1'($urandom);
      cycle("reset");
    end
    chk("reset.valid", 192'(bus.valid_o), 192'(0));
    rst = 1; flush = 0;

    add_in(5'd3, 5'd1, 5'd2);
    cycle("pass");
    chk("pass.valid", 192'(bus.valid_o), 192'(1));
    chk("pass.rs_data", 192'(bus.rs_data_o), 192'(5));

    lw_in(5'd8, 5'd0);
    cycle("lw8");
    add_in(5'd9, 5'd8, 5'd1);
    cycle("lu.stall");
    chk("lu.bubble", 192'({bus.valid_o, bus.RegWrite_o,
        bus.MemRead_o}), 192'(0));
    chk("lu.bcnt1", 192'(bus.bubble_cnt_o), 192'(1));
    cycle("lu.reissue");
    chk("lu.add_in_ex", 192'(bus.rd_addr_o), 192'(9));

    // back-to-back loads: second load stalls once then stalls its user
    lw_in(5'd8, 5'd0);   cycle("bb.lw8");
    lw_in(5'd9, 5'd8);   cycle("bb.stall");
    cycle("bb.lw9");
    add_in(5'd10, 5'd9, 5'd9); cycle("bb.stall2");
    cycle("bb.add");

    lw_in(5'd0, 5'd0);   cycle("zr.lw0");
    add_in(5'd4, 5'd0, 5'd0);  cycle("zr.nostall");
    chk("zr.valid", 192'(bus.valid_o), 192'(1));

    rst = 0; cycle("fs.rst"); rst = 1;
    lw_in(5'd8, 5'd0);   cycle("fs.lw8");
    add_in(5'd9, 5'd8, 5'd1);
    flush = 1; cycle("fs.flush"); flush = 0;
    chk("fs.fcnt1", 192'(bus.flush_cnt_o), 192'(1));
    chk("fs.bcnt0", 192'(bus.bubble_cnt_o), 192'(0));

    lw_in(5'd8, 5'd0);   cycle("rs.lw8");
    add_in(5'd9, 5'd1, 5'd8);
    rst = 0; cycle("rs.mid"); rst = 1;

    for (int i = 0; i < 400; i++) begin
      rand_in();
      flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) != 0);
      cycle("rand");
    end
    rst = 1;

    flush = 1;
    for (int i = 0; i < 20; i++) begin
      rand_in(); cycle("sat");
    end
    flush = 0;
    chk("sat.hold15", 192'(bus.flush_cnt_o), 192'(15));
    rst = 0; rand_in(); cycle("sat.rst"); rst = 1;
    chk("sat.cleared", 192'(bus.flush_cnt_o), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
